// File: rtl/reg_bank_flat.sv
// 64 x 16-bit register bank with direct write port, burst stream loader and global clear.
// Optional build macro REG_ZERO_HARDWIRED_EN: register 0 reads as constant zero.
module reg_bank_flat #(
  parameter int NUM_REGS = 64,
  parameter int DATA_W   = 16,
  parameter int IDX_W    = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       load_start,
  input  logic [IDX_W-1:0]           load_base,
  input  logic [IDX_W:0]             load_count,
  input  logic                       strm_valid,
  input  logic [DATA_W-1:0]          strm_data,
  output logic                       strm_ready,
  input  logic                       clr_req,
  output logic                       busy,
  output logic                       load_done,
  output logic                       wr_err,
  output logic [IDX_W-1:0]           strm_idx,
  output logic [NUM_REGS*DATA_W-1:0] regs
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOAD = 1'b1} state_t;

`ifdef REG_ZERO_HARDWIRED_EN
  localparam logic ZERO_HW = 1'b1;
`else
  localparam logic ZERO_HW = 1'b0;
`endif

  state_t                       state_r;
  logic                         busy_r;
  logic                         strm_ready_r;
  logic                         load_done_r;
  logic                         wr_err_r;
  logic [IDX_W-1:0]             strm_idx_r;
  logic [IDX_W:0]               remaining_r;
  logic [NUM_REGS*DATA_W-1:0]   regs_r;

  logic                         beat_s;
  logic                         dwr_s;
  logic                         swr_s;

  // Write-enable decode for both write paths, including the hardwired-zero gate
  always_comb begin
    beat_s = strm_valid & strm_ready_r;
    dwr_s  = 1'b0;
    swr_s  = 1'b0;
    if (state_r == ST_IDLE) begin
      dwr_s = wr_en & ~(ZERO_HW & (wr_idx == 6'd0));
    end else begin
      dwr_s = 1'b0;
    end
    if (beat_s) begin
      swr_s = ~(ZERO_HW & (strm_idx_r == 6'd0));
    end else begin
      swr_s = 1'b0;
    end
  end

  // Register file storage; clear outranks both write paths
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_r <= '0;
    end else if (clr_req) begin
      regs_r <= '0;
    end else begin
      if (dwr_s) regs_r[{wr_idx, 4'd0} +: DATA_W] <= wr_data;
      if (swr_s) regs_r[{strm_idx_r, 4'd0} +: DATA_W] <= strm_data;
    end
  end

  // Load FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      strm_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
      wr_err_r     <= 1'b0;
      strm_idx_r   <= 6'd0;
      remaining_r  <= 7'd0;
    end else if (clr_req) begin
      // strm_idx deliberately keeps its value across a clear
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      strm_ready_r <= 1'b0;
      load_done_r  <= 1'b0;
      wr_err_r     <= 1'b0;
      remaining_r  <= 7'd0;
    end else begin
      load_done_r <= 1'b0;
      wr_err_r    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load_start) begin
            state_r      <= ST_LOAD;
            busy_r       <= 1'b1;
            strm_ready_r <= 1'b1;
            strm_idx_r   <= load_base;
            remaining_r  <= (load_count == 7'd0) ? 7'd64 : load_count;
          end
        end
        ST_LOAD: begin
          if (wr_en) wr_err_r <= 1'b1;
          if (beat_s) begin
            strm_idx_r  <= strm_idx_r + 6'd1;
            remaining_r <= remaining_r - 7'd1;
            if (remaining_r == 7'd1) begin
              state_r      <= ST_IDLE;
              busy_r       <= 1'b0;
              strm_ready_r <= 1'b0;
              load_done_r  <= 1'b1;
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          strm_ready_r <= 1'b0;
          remaining_r  <= 7'd0;
        end
      endcase
    end
  end

  assign strm_ready = strm_ready_r;
  assign busy       = busy_r;
  assign load_done  = load_done_r;
  assign wr_err     = wr_err_r;
  assign strm_idx   = strm_idx_r;
  assign regs       = regs_r;

endmodule

// File: tb/tb_reg_bank_flat.sv
// Directed bench for reg_bank_flat: per-cycle reference model comparison plus literal spot checks.
module tb_reg_bank_flat;

  logic         clk = 1'b0;
  logic         reset, wr_en, load_start, strm_valid, clr_req;
  logic [5:0]   wr_idx, load_base;
  logic [6:0]   load_count;
  logic [15:0]  wr_data, strm_data;
  logic         strm_ready, busy, load_done, wr_err;
  logic [5:0]   strm_idx;
  logic [1023:0] regs;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [15:0] mem [64];
  bit          m_busy, m_done, m_err;
  int          m_rem;
  int          m_idx;

  reg_bank_flat dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .load_start(load_start), .load_base(load_base), .load_count(load_count),
    .strm_valid(strm_valid), .strm_data(strm_data), .strm_ready(strm_ready),
    .clr_req(clr_req), .busy(busy), .load_done(load_done), .wr_err(wr_err),
    .strm_idx(strm_idx), .regs(regs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit storable(input int idx);
`ifdef REG_ZERO_HARDWIRED_EN
    return idx != 0;
`else
    return 1'b1;
`endif
  endfunction

  // Reference model: advance on each rising edge from the stable inputs
  always @(posedge clk) begin
    if (reset) begin
      foreach (mem[i]) mem[i] = 16'h0;
      m_busy = 0; m_done = 0; m_err = 0; m_rem = 0; m_idx = 0;
    end else if (clr_req) begin
      foreach (mem[i]) mem[i] = 16'h0;
      m_busy = 0; m_done = 0; m_err = 0; m_rem = 0;
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_busy) begin
        if (wr_en && storable(int'(wr_idx))) mem[wr_idx] = wr_data;
        if (load_start) begin
          m_busy = 1;
          m_idx  = int'(load_base);
          m_rem  = (load_count == 7'd0) ? 64 : int'(load_count);
        end
      end else begin
        if (wr_en) m_err = 1;
        if (strm_valid) begin
          if (storable(m_idx)) mem[m_idx] = strm_data;
          m_idx = (m_idx + 1) % 64;
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  // Compare every DUT output against the model on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {15'd0, busy}, {15'd0, m_busy});
      chk("strm_ready", {15'd0, strm_ready}, {15'd0, m_busy});
      chk("load_done", {15'd0, load_done}, {15'd0, m_done});
      chk("wr_err", {15'd0, wr_err}, {15'd0, m_err});
      chk("strm_idx", {10'd0, strm_idx}, 16'(m_idx));
      for (int i = 0; i < 64; i++) chk($sformatf("regs[%0d]", i), regs[16*i +: 16], mem[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rd(input int i);
    return regs[16*i +: 16];
  endfunction

  task automatic start_load(input logic [5:0] base, input logic [6:0] cnt);
    load_start = 1'b1; load_base = base; load_count = cnt;
    tick();
    load_start = 1'b0;
  endtask

  logic [1023:0] tmp;
  int bcnt;
  logic [2:0] gap_pat [6] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0, 3'd1};
  logic [15:0] burst4 [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_idx = 6'd0; wr_data = 16'h0;
    load_start = 1'b0; load_base = 6'd0; load_count = 7'd0;
    strm_valid = 1'b0; strm_data = 16'h0; clr_req = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst busy", {15'd0, busy}, 16'h0);
    chk("rst strm_idx", {10'd0, strm_idx}, 16'h0);
    chk("rst regs", {15'd0, |regs}, 16'h0);
    reset = 1'b0;

    // direct write idx 5
    wr_en = 1'b1; wr_idx = 6'd5; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    chk("wr5", regs[95:80], 16'hBEEF);
    tmp = regs; tmp[95:80] = 16'h0;
    chk("wr5 others", {15'd0, |tmp}, 16'h0);

    // wrapping burst 62..1
    start_load(6'd62, 7'd4);
    bcnt = 0;
    strm_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      strm_data = burst4[i];
      bcnt += int'(busy);
      tick();
    end
    strm_valid = 1'b0;
    chk("b4 busy cycles", 16'(bcnt), 16'd4);
    chk("b4 done", {15'd0, load_done}, 16'h1);
    chk("b4 busy low", {15'd0, busy}, 16'h0);
    chk("b4 idx", {10'd0, strm_idx}, 16'd2);
    chk("b4 r62", rd(62), 16'h1111);
    chk("b4 r63", rd(63), 16'h2222);
    chk("b4 r0", rd(0), 16'h3333);
    chk("b4 r1", rd(1), 16'h4444);
    tick();
    chk("b4 done pulse", {15'd0, load_done}, 16'h0);

    // gapped burst of 3
    start_load(6'd10, 7'd3);
    for (int i = 0; i < 6; i++) begin
      strm_valid = gap_pat[i][0];
      strm_data = 16'hC000 + 16'(i);
      tick();
    end
    strm_valid = 1'b0;
    chk("gap done", {15'd0, load_done}, 16'h1);
    chk("gap r10", rd(10), 16'hC000);
    chk("gap r11", rd(11), 16'hC003);
    chk("gap r12", rd(12), 16'hC005);
    tick();

    // load_start with same-cycle direct write, then write during LOAD
    wr_en = 1'b1; wr_idx = 6'd8; wr_data = 16'h1234;
    start_load(6'd20, 7'd2);
    chk("co r8", rd(8), 16'h1234);
    wr_idx = 6'd7; wr_data = 16'hAAAA;
    tick();
    wr_en = 1'b0;
    chk("drop err", {15'd0, wr_err}, 16'h1);
    chk("drop r7", rd(7), 16'h0);
    strm_valid = 1'b1; strm_data = 16'h5555;
    tick();
    chk("drop err pulse", {15'd0, wr_err}, 16'h0);
    strm_data = 16'h6666;
    tick();
    strm_valid = 1'b0;
    chk("drop done", {15'd0, load_done}, 16'h1);
    chk("drop r21", rd(21), 16'h6666);

    // clear after 2 of 5 beats, with a same-cycle beat and direct write
    start_load(6'd30, 7'd5);
    strm_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      strm_data = 16'h9000 + 16'(i);
      tick();
    end
    clr_req = 1'b1; wr_en = 1'b1; wr_idx = 6'd3; wr_data = 16'hFFFF;
    tick();
    clr_req = 1'b0; wr_en = 1'b0; strm_valid = 1'b0;
    chk("clr regs", {15'd0, |regs}, 16'h0);
    chk("clr busy", {15'd0, busy}, 16'h0);
    chk("clr wr_err", {15'd0, wr_err}, 16'h0);
    chk("clr idx kept", {10'd0, strm_idx}, 16'd32);
    tick();
    chk("clr no done", {15'd0, load_done}, 16'h0);

    // clear beats a same-cycle load_start
    clr_req = 1'b1;
    start_load(6'd40, 7'd1);
    clr_req = 1'b0;
    chk("clr vs start", {15'd0, busy}, 16'h0);

    // normal single-word load afterwards
    start_load(6'd40, 7'd1);
    strm_valid = 1'b1; strm_data = 16'h7777;
    tick();
    strm_valid = 1'b0;
    chk("post r40", rd(40), 16'h7777);
    chk("post done", {15'd0, load_done}, 16'h1);

    // count 0 = 64 words, with an ignored load_start mid-burst
    start_load(6'd0, 7'd0);
    strm_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      strm_data = 16'(i * 3 + 1);
      load_start = (i == 10);
      load_base = 6'd50; load_count = 7'd1;
      tick();
    end
    strm_valid = 1'b0; load_start = 1'b0;
    chk("b64 done", {15'd0, load_done}, 16'h1);
    chk("b64 idx", {10'd0, strm_idx}, 16'd0);
    chk("b64 r63", rd(63), 16'd190);
`ifdef REG_ZERO_HARDWIRED_EN
    chk("b64 r0", rd(0), 16'h0);
`else
    chk("b64 r0", rd(0), 16'h1);
`endif

    // reset in mid-burst
    start_load(6'd12, 7'd5);
    strm_valid = 1'b1; strm_data = 16'h4321;
    tick();
    strm_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid rst busy", {15'd0, busy}, 16'h0);
    chk("mid rst idx", {10'd0, strm_idx}, 16'h0);
    chk("mid rst regs", {15'd0, |regs}, 16'h0);

`ifdef REG_ZERO_HARDWIRED_EN
    wr_en = 1'b1; wr_idx = 6'd0; wr_data = 16'h5A5A;
    tick();
    wr_en = 1'b0;
    chk("hw0 wr", rd(0), 16'h0);
    chk("hw0 err", {15'd0, wr_err}, 16'h0);
    start_load(6'd0, 7'd2);
    strm_valid = 1'b1; strm_data = 16'hAB00;
    tick();
    strm_data = 16'hAB01;
    tick();
    strm_valid = 1'b0;
    chk("hw0 r0", rd(0), 16'h0);
    chk("hw0 r1", rd(1), 16'hAB01);
    chk("hw0 done", {15'd0, load_done}, 16'h1);
`endif

    tick();
    tick();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/reg_bank_flat.md
Name: reg_bank_flat

Overview:
- 64-entry x 16-bit register bank that produces the flat 1024-bit register bus consumed by the downstream register-select mux.
- Register i occupies bits [16*i +: 16] of the bus.
- Two write paths: a single-word direct write port, and a burst loader that accepts a valid/ready stream and writes consecutive registers with an auto-incrementing index.
- Also provides a one-cycle global clear.

Parameters:
- NUM_REGS, 64: number of registers; fixed at 64 for this revision.
- DATA_W, 16: register width in bits.
- IDX_W, 6: register index width; equals log2(NUM_REGS).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  direct write strobe.
- wr_idx  input  6  direct write register index.
- wr_data  input  16  direct write data.
- load_start  input  1  single-cycle pulse that starts a burst load.
- load_base  input  6  first register index of the burst; sampled on load_start.
- load_count  input  7  number of words in the burst, 1..64; 0 means 64; sampled on load_start.
- strm_valid  input  1  stream data valid.
- strm_data  input  16  stream data word.
- strm_ready  output  1  stream ready; high only in state LOAD.
- clr_req  input  1  single-cycle pulse that clears all registers.
- busy  output  1  high while in state LOAD.
- load_done  output  1  one-cycle pulse after the last burst word is written.
- wr_err  output  1  one-cycle pulse when a direct write is dropped.
- strm_idx  output  6  index the next accepted stream word will be written to.
- regs  output  1024  flat register bus; register i at [16*i +: 16].

Behaviour:
- Reset values: regs = all 0; state = IDLE; strm_ready = 0; busy = 0; load_done = 0; wr_err = 0; strm_idx = 0; remaining-count register = 0.
- FSM has two states, IDLE and LOAD. strm_ready = busy = (state == LOAD); both are registered.
- Direct write, IDLE only: wr_en=1 writes regs[wr_idx] = wr_data at the clock edge. The new value is visible on regs the next cycle (1-cycle latency).
- Direct write in LOAD: the write is dropped and wr_err pulses high for 1 cycle on the following cycle. No register changes.
- IDLE -> LOAD on load_start=1:
  - strm_idx <= load_base.
  - remaining <= (load_count == 0) ? 64 : load_count.
  - strm_ready goes high the next cycle.
- load_start and wr_en in the same IDLE cycle: the direct write is performed and the load starts; both take effect.
- load_start while already in LOAD: ignored.
- Stream beat = strm_valid & strm_ready. On each beat:
  - regs[strm_idx] <= strm_data.
  - strm_idx <= strm_idx + 1, modulo 64 (63 wraps to 0).
  - remaining <= remaining - 1.
- Last beat (remaining == 1): state <= IDLE, and strm_ready drops the next cycle. load_done is high for exactly 1 cycle, in the cycle after the last beat (coincident with strm_ready = 0).
- strm_valid low in LOAD: stall, no change to state or registers. There is no timeout.
- clr_req has the highest priority, in any state:
  - All regs are 0 on the next cycle.
  - state <= IDLE and remaining <= 0.
  - A load in progress is aborted: no load_done, and the partially written registers are zeroed.
  - A same-cycle wr_en or stream beat is discarded; wr_err is not raised.
- clr_req and load_start in the same cycle: clear wins and the load is not started.
- Reset mid-burst: behaves as full reset, identical to the reset values above.
- strm_idx holds its last value in IDLE. It is reloaded only by load_start and reset; clr_req does not alter it.

Optional Feature:
- Macro: REG_ZERO_HARDWIRED_EN.
- Defined:
  - regs[15:0] is constant 0.
  - Direct writes to index 0 are dropped silently (no wr_err).
  - Stream beats targeting index 0 are consumed and counted (strm_idx and remaining advance) but not stored.
- Undefined: register 0 is an ordinary writable register.

Test Plan:
- Reset, then direct write wr_idx=5, wr_data=0xBEEF -> next cycle regs[95:80]=0xBEEF and all other bits 0.
- load_start with base=62, count=4; stream 0x1111, 0x2222, 0x3333, 0x4444 with valid held high -> regs 62, 63, 0, 1 hold those values; strm_idx=2; load_done is a single pulse the cycle after the 4th beat; busy is high for exactly 4 cycles.
- Burst with count=3 and strm_valid gapped (1,0,0,1,0,1) -> writes occur only on valid cycles; load_done follows the 3rd accepted beat.
- wr_en (idx=7, data=0xAAAA) during LOAD -> regs[7] unchanged; wr_err pulses 1 cycle; the burst completes normally.
- clr_req after 2 of 5 burst beats -> all regs 0 next cycle; busy=0; no load_done; a later load_start works normally.
- With REG_ZERO_HARDWIRED_EN defined: direct write idx=0, data=0x5A5A -> regs[15:0] stays 0 and wr_err=0. Burst base=0, count=2 -> only regs[1] is written, and load_done still pulses.
